// File: rtl/if_id_stage_if.sv
// Handshake bundle between the fetch side, the IF/ID pipeline register and decode.
// The stage drives pc_out..stall_count; everything else comes from fetch/EX.
interface if_id_stage_if;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        instr_valid_in;
    logic        flush_in;
    logic        idex_memtoreg;
    logic [4:0]  idex_rd;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        valid_out;
    logic        pc_write;
    logic        idex_bubble;
    logic [15:0] stall_count;

    modport master (
        output pc_in, instr_in, instr_valid_in, flush_in, idex_memtoreg, idex_rd,
        input  pc_out, instr_out, valid_out, pc_write, idex_bubble, stall_count
    );

    modport slave (
        input  pc_in, instr_in, instr_valid_in, flush_in, idex_memtoreg, idex_rd,
        output pc_out, instr_out, valid_out, pc_write, idex_bubble, stall_count
    );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection, flush squashing,
// fetch-miss bubble insertion and a saturating stall counter.
module if_id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input logic          clk,
    input logic          rst_n,
    if_id_stage_if.slave bus
);

    typedef enum logic [2:0] {
        ACT_RESET = 3'd0,
        ACT_FLUSH = 3'd1,
        ACT_STALL = 3'd2,
        ACT_MISS  = 3'd3,
        ACT_LOAD  = 3'd4
    } act_e;

    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic        valid_r;
    logic [15:0] stall_count_r;

    logic [6:0]  opcode_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic        hazard_s;
    logic        pc_write_s;
    logic        idex_bubble_s;
    act_e        act_s;

    function automatic logic rs1_used_f(input logic [6:0] opcode);
        case (opcode)
            7'b0110111: rs1_used_f = 1'b0;
            7'b0010111: rs1_used_f = 1'b0;
            7'b1101111: rs1_used_f = 1'b0;
            default:    rs1_used_f = 1'b1;
        endcase
    endfunction

    function automatic logic rs2_used_f(input logic [6:0] opcode);
        case (opcode)
            7'b0110011: rs2_used_f = 1'b1;
            7'b0100011: rs2_used_f = 1'b1;
            7'b1100011: rs2_used_f = 1'b1;
            default:    rs2_used_f = 1'b0;
        endcase
    endfunction

    assign opcode_s = instr_r[6:0];
    assign rs1_s    = instr_r[19:15];
    assign rs2_s    = instr_r[24:20];

    // A bubble is masked by valid_r so its fields can never match idex_rd.
    assign hazard_s = valid_r & bus.idex_memtoreg & (bus.idex_rd != 5'd0) &
                      ((rs1_used_f(opcode_s) & (rs1_s == bus.idex_rd)) |
                       (rs2_used_f(opcode_s) & (rs2_s == bus.idex_rd)));

    // Select this cycle's action by priority and derive the same-cycle controls.
    always_comb begin
        act_s         = ACT_LOAD;
        pc_write_s    = 1'b1;
        idex_bubble_s = 1'b0;
        if (!rst_n) begin
            act_s         = ACT_RESET;
            pc_write_s    = 1'b0;
            idex_bubble_s = 1'b1;
        end else if (bus.flush_in) begin
            act_s         = ACT_FLUSH;
            pc_write_s    = 1'b1;
            idex_bubble_s = 1'b1;
        end else if (hazard_s) begin
            act_s         = ACT_STALL;
            pc_write_s    = 1'b0;
            idex_bubble_s = 1'b1;
        end else if (!bus.instr_valid_in) begin
            act_s         = ACT_MISS;
            pc_write_s    = 1'b0;
            idex_bubble_s = 1'b0;
        end else begin
            act_s         = ACT_LOAD;
            pc_write_s    = 1'b1;
            idex_bubble_s = 1'b0;
        end
    end

    // Pipeline register and stall counter update.
    always_ff @(posedge clk) begin
        case (act_s)
            ACT_RESET: begin
                pc_r          <= 32'd0;
                instr_r       <= NOP_INSTR;
                valid_r       <= 1'b0;
                stall_count_r <= 16'd0;
            end
            ACT_FLUSH, ACT_MISS: begin
                pc_r    <= bus.pc_in;
                instr_r <= NOP_INSTR;
                valid_r <= 1'b0;
            end
            ACT_STALL: begin
                if (stall_count_r != 16'hFFFF) begin
                    stall_count_r <= stall_count_r + 16'd1;
                end
            end
            ACT_LOAD: begin
                pc_r    <= bus.pc_in;
                instr_r <= bus.instr_in;
                valid_r <= 1'b1;
            end
            default: begin
                pc_r          <= 32'd0;
                instr_r       <= NOP_INSTR;
                valid_r       <= 1'b0;
                stall_count_r <= 16'd0;
            end
        endcase
    end

    assign bus.pc_out      = pc_r;
    assign bus.instr_out   = instr_r;
    assign bus.valid_out   = valid_r;
    assign bus.stall_count = stall_count_r;
    assign bus.pc_write    = pc_write_s;
    assign bus.idex_bubble = idex_bubble_s;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed-vector bench for if_id_stage: the driver queues hand-computed
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_if_id_stage;

    logic clk;
    logic rst_n;

    if_id_stage_if bus ();

    if_id_stage #(.NOP_INSTR(32'h00000013)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected values: comb controls for this cycle, and the register state
    // visible this cycle (the result of the previous edge).
    typedef struct {
        string       name;
        logic        pcw;
        logic        bub;
        logic        chk;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic apply(
        input string       name,
        input logic        rst,
        input logic [31:0] pc,
        input logic [31:0] instr,
        input logic        v,
        input logic        flush,
        input logic        mtr,
        input logic [4:0]  rd,
        input logic        e_pcw,
        input logic        e_bub,
        input logic        e_chk,
        input logic [31:0] e_pc,
        input logic [31:0] e_instr,
        input logic        e_valid,
        input logic [15:0] e_cnt
    );
        exp_t e;
        @(posedge clk);
        #2;
        rst_n              = rst;
        bus.pc_in          = pc;
        bus.instr_in       = instr;
        bus.instr_valid_in = v;
        bus.flush_in       = flush;
        bus.idex_memtoreg  = mtr;
        bus.idex_rd        = rd;
        e.name  = name;
        e.pcw   = e_pcw;
        e.bub   = e_bub;
        e.chk   = e_chk;
        e.pc    = e_pc;
        e.instr = e_instr;
        e.valid = e_valid;
        e.cnt   = e_cnt;
        q.push_back(e);
    endtask

    // Monitor: compare the oldest expectation once inputs have settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if (bus.pc_write !== e.pcw) begin
                    miscompares++;
                    $display("FAIL %s pc_write got %b want %b", e.name, bus.pc_write, e.pcw);
                end
                if (bus.idex_bubble !== e.bub) begin
                    miscompares++;
                    $display("FAIL %s idex_bubble got %b want %b", e.name, bus.idex_bubble, e.bub);
                end
                if (e.chk) begin
                    if (bus.pc_out !== e.pc) begin
                        miscompares++;
                        $display("FAIL %s pc_out got %h want %h", e.name, bus.pc_out, e.pc);
                    end
                    if (bus.instr_out !== e.instr) begin
                        miscompares++;
                        $display("FAIL %s instr_out got %h want %h", e.name, bus.instr_out, e.instr);
                    end
                    if (bus.valid_out !== e.valid) begin
                        miscompares++;
                        $display("FAIL %s valid_out got %b want %b", e.name, bus.valid_out, e.valid);
                    end
                    if (bus.stall_count !== e.cnt) begin
                        miscompares++;
                        $display("FAIL %s stall_count got %h want %h", e.name, bus.stall_count, e.cnt);
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        rst_n              = 1'b0;
        bus.pc_in          = 32'd0;
        bus.instr_in       = 32'd0;
        bus.instr_valid_in = 1'b0;
        bus.flush_in       = 1'b0;
        bus.idex_memtoreg  = 1'b0;
        bus.idex_rd        = 5'd0;

        //     name          rst   pc_in         instr_in      v     fl    mtr   rd     pcw   bub   chk   pc_out        instr_out     vld   cnt
        apply("reset_comb",  1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 16'h0000);
        apply("reset_state", 1'b1, 32'h0000_0100, 32'h0050_0093, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0013, 1'b0, 16'h0000);
        apply("normal_load", 1'b1, 32'h0000_0104, 32'h0020_81B3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0050_0093, 1'b1, 16'h0000);
        apply("load_use",    1'b1, 32'h0000_0108, 32'h0000_00B7, 1'b1, 1'b0, 1'b1, 5'd2, 1'b0, 1'b1, 1'b1, 32'h0000_0104, 32'h0020_81B3, 1'b1, 16'h0000);
        apply("stall_held",  1'b1, 32'h0000_0108, 32'h0000_00B7, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1, 32'h0000_0104, 32'h0020_81B3, 1'b1, 16'h0001);
        apply("lui_rd0",     1'b1, 32'h0000_010C, 32'h0000_80B7, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 32'h0000_0108, 32'h0000_00B7, 1'b1, 16'h0001);
        apply("lui_rs1_fld", 1'b1, 32'h0000_0110, 32'h0011_8093, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 32'h0000_010C, 32'h0000_80B7, 1'b1, 16'h0001);
        apply("itype_rs2",   1'b1, 32'h0000_0114, 32'h0000_0033, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 32'h0000_0110, 32'h0011_8093, 1'b1, 16'h0001);
        apply("rd0_rs1_0",   1'b1, 32'h0000_0118, 32'h0020_81B3, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 32'h0000_0114, 32'h0000_0033, 1'b1, 16'h0001);
        apply("flush_haz",   1'b1, 32'h0000_0200, 32'h0020_81B3, 1'b1, 1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 1'b1, 32'h0000_0118, 32'h0020_81B3, 1'b1, 16'h0001);
        apply("fetch_miss",  1'b1, 32'h0000_0204, 32'h0020_81B3, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_0013, 1'b0, 16'h0001);
        apply("after_miss",  1'b1, 32'h0000_0208, 32'h0020_81B3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 32'h0000_0204, 32'h0000_0013, 1'b0, 16'h0001);

        // Hold a load-use hazard long enough to drive stall_count into saturation.
        for (int i = 0; i < 65536; i++) begin
            apply("stall_sat", 1'b1, 32'h0000_020C, 32'h0000_0013, 1'b1, 1'b0, 1'b1, 5'd2,
                  1'b0, 1'b1, 1'b1, 32'h0000_0208, 32'h0020_81B3, 1'b1,
                  (i < 65534) ? 16'(i + 1) : 16'hFFFF);
        end

        apply("rst_in_stall", 1'b0, 32'h0000_020C, 32'h0000_0013, 1'b1, 1'b0, 1'b1, 5'd2, 1'b0, 1'b1, 1'b1, 32'h0000_0208, 32'h0020_81B3, 1'b1, 16'hFFFF);
        apply("rst_release",  1'b1, 32'h0000_0300, 32'h0050_0093, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0013, 1'b0, 16'h0000);
        apply("post_reset",   1'b1, 32'h0000_0304, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 32'h0050_0093, 1'b1, 16'h0000);

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain %0d expectations left, want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 The block SHALL expose the parameter NOP_INSTR, default 32'h00000013 (addi x0,x0,0), the instruction injected on bubbles.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 pc_in  input  32  fetch-stage PC of the instruction on instr_in.
REQ-005 instr_in  input  32  instruction word from instruction memory.
REQ-006 instr_valid_in  input  1  instr_in is valid this cycle; 0 means fetch miss.
REQ-007 flush_in  input  1  taken branch or jump resolved in EX; squash the younger instructions.
REQ-008 idex_memtoreg  input  1  instruction currently in ID/EX is a load.
REQ-009 idex_rd  input  5  destination register of the instruction in ID/EX.
REQ-010 pc_out  output  32  registered PC to decode.
REQ-011 instr_out  output  32  registered instruction to decode and ID/EX.
REQ-012 valid_out  output  1  instr_out is a real instruction, not a bubble.
REQ-013 pc_write  output  1  combinational; 1 lets the PC register advance this cycle.
REQ-014 idex_bubble  output  1  combinational; 1 forces zero control fields into ID/EX this edge.
REQ-015 stall_count  output  16  registered count of load-use stall cycles.

Function
REQ-016 Decode fields SHALL come from instr_out: rs1=[19:15], rs2=[24:20], opcode=[6:0].
REQ-017 rs1_used SHALL be 1 unless opcode is 0110111 (LUI), 0010111 (AUIPC) or 1101111 (JAL).
REQ-018 rs2_used SHALL be 1 only for opcode 0110011 (R-type), 0100011 (store) or 1100011 (branch).
REQ-019 The hazard condition SHALL be: valid_out & idex_memtoreg & (idex_rd!=0) & ((rs1_used & rs1==idex_rd) | (rs2_used & rs2==idex_rd)).
REQ-020 The next-state priority SHALL be: reset > flush_in > hazard > !instr_valid_in > normal load.
REQ-021 On flush_in=1: instr_out<=NOP_INSTR, valid_out<=0, pc_out<=pc_in, pc_write=1, idex_bubble=1; any simultaneous hazard SHALL be ignored and stall_count SHALL not increment.
REQ-022 On a hazard without flush: pc_out, instr_out and valid_out SHALL hold, pc_write=0, idex_bubble=1, and stall_count SHALL increment.
REQ-023 When instr_valid_in=0 with no flush and no hazard: instr_out<=NOP_INSTR, valid_out<=0, pc_out<=pc_in, pc_write=0, idex_bubble=0.
REQ-024 On a normal load: pc_out<=pc_in, instr_out<=instr_in, valid_out<=1, pc_write=1, idex_bubble=0.
REQ-025 Latency SHALL be one cycle from pc_in/instr_in to pc_out/instr_out; pc_write and idex_bubble SHALL react in the same cycle as their inputs.
REQ-026 stall_count SHALL saturate at 16'hFFFF and never wrap.
REQ-027 A load-use hazard SHALL last exactly one cycle in a correctly connected pipeline, because the bubble clears idex_memtoreg; the block itself SHALL not limit stall length.
REQ-028 A bubble (valid_out=0) SHALL never raise a hazard, whatever its field values.

Reset
REQ-029 While rst_n=0 at a rising edge: pc_out<=0, instr_out<=NOP_INSTR, valid_out<=0, stall_count<=0.
REQ-030 While rst_n=0: pc_write=0 and idex_bubble=1, combinationally.
REQ-031 Reset asserted mid-stall or mid-flush SHALL override both; the first cycle after release SHALL behave as a normal load.

Verification
REQ-032 Normal flow: pc_in=0x100, instr_in=0x00500093, instr_valid_in=1 -> next cycle pc_out=0x100, instr_out=0x00500093, valid_out=1, pc_write=1, idex_bubble=0.
REQ-033 Load-use: instr_out=0x002081B3 (add x3,x1,x2, valid), idex_memtoreg=1, idex_rd=2 -> pc_write=0, idex_bubble=1, outputs held, stall_count 0->1; next cycle with idex_memtoreg=0 -> advances.
REQ-034 No false hazard: instr_out=0x000000B7 (LUI x1), idex_rd=0; idex_rd=1 with opcode 0010011 and rs2 field=1 -> no stall in either case; idex_rd=0 with rs1=0 -> no stall.
REQ-035 Flush beats hazard: hazard condition true and flush_in=1, pc_in=0x200 -> instr_out=0x00000013, valid_out=0, pc_out=0x200, pc_write=1, stall_count unchanged.
REQ-036 Fetch miss and reset: instr_valid_in=0 -> bubble loaded, pc_write=0; stall_count forced to 0xFFFF then one more hazard -> stays 0xFFFF; rst_n=0 during a stall -> all reset values of REQ-029 on the next edge.
